// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types and constants: FSM states, instruction size and the
// entry layout held in the prefetch FIFO.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } FetchStates;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits are forced to zero.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instr} with circular pointers, flush,
// occupancy count and a combinational head view of the registered storage.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fetch_entry_t  i_wdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full,
    output fetch_entry_t  o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pop on empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: single-outstanding req/ack fetcher feeding a
// prefetch FIFO, with branch/jump redirect that flushes and refetches.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    output logic        oImemReq,
    output logic [31:0] oImemAddr,
    input  logic        iImemAck,
    input  logic [31:0] iImemRdata,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    FetchStates    r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_imem_req;
    logic [31:0]   r_imem_addr;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_room_after_push;
    logic [31:0]   w_next_pc;
    logic [31:0]   w_redirect_pc;

    assign w_ack         = r_imem_req && iImemAck;
    assign w_pop         = !w_empty && iReady && !iRedirect;
    assign w_push        = (r_state == REQ) && w_ack && !iRedirect;
    assign w_next_pc     = r_fetch_pc + INSTR_BYTES;
    assign w_redirect_pc = align_pc(iRedirectPC);
    assign w_push_entry  = {r_fetch_pc, iImemRdata};

    // Occupancy after this cycle's push (and possible pop) stays below DEPTH.
    assign w_room_after_push = w_pop || (w_count < CW'(DEPTH - 1));

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk  (iClk),
        .i_rst  (iRst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(iRedirect),
        .i_wdata(w_push_entry),
        .o_count(w_count),
        .o_empty(w_empty),
        .o_full (w_full),
        .o_head (w_head)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iRedirect) begin
                        r_fetch_pc  <= w_redirect_pc;
                        r_imem_addr <= w_redirect_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= REQ;
                    end else if (!w_full) begin
                        r_imem_addr <= r_fetch_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (iRedirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        // Ack on the redirect cycle is dropped and the target is issued at once.
                        if (w_ack) begin
                            r_imem_addr <= w_redirect_pc;
                        end else begin
                            r_state <= DISCARD;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_room_after_push) begin
                            r_imem_addr <= w_next_pc;
                        end else begin
                            r_imem_req <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (iRedirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    if (w_ack) begin
                        r_imem_addr <= iRedirect ? w_redirect_pc : r_fetch_pc;
                        r_state     <= REQ;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign oImemReq     = r_imem_req;
    assign oImemAddr    = r_imem_addr;
    assign oValid       = !w_empty;
    assign oInstruction = w_head.instr;
    assign oPC          = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SALT     = 32'hA5A5_0000;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemAck;
    logic [31:0] iImemRdata;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInstruction;
    logic [31:0] oPC;
    logic        iRedirect;
    logic [31:0] iRedirectPC;

    always #5 iClk = ~iClk;

    // Memory returns the address scrambled with a salt so each word is traceable.
    assign iImemRdata = oImemAddr ^ SALT;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .oImemReq    (oImemReq),
        .oImemAddr   (oImemAddr),
        .iImemAck    (iImemAck),
        .iImemRdata  (iImemRdata),
        .oValid      (oValid),
        .iReady      (iReady),
        .oInstruction(oInstruction),
        .oPC         (oPC),
        .iRedirect   (iRedirect),
        .iRedirectPC (iRedirectPC)
    );

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc_no, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] pc);
        check({name, ".req"}, {31'd0, oImemReq}, {31'd0, req});
        check({name, ".addr"}, oImemAddr, addr);
        check({name, ".valid"}, {31'd0, oValid}, {31'd0, valid});
        if (valid) begin
            check({name, ".pc"}, oPC, pc);
            check({name, ".instr"}, oInstruction, pc ^ SALT);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic rdy,
                         input logic redir, input logic [31:0] tgt);
        iRst        = rst;
        iImemAck    = ack;
        iReady      = rdy;
        iRedirect   = redir;
        iRedirectPC = tgt;
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
        cyc_no++;
    endtask

    // Reference model: fetched words queue in order; one request may be in flight,
    // possibly marked to be dropped because a redirect overtook it.
    logic [63:0] mq[$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;

    task automatic model_step(input bit rst, input bit ack, input bit rdy,
                              input bit redir, input logic [31:0] tgt);
        int unsigned pre = mq.size();
        bit acked = m_out && ack;
        bit start;
        if (rst) begin
            mq.delete();
            m_out  = 0;
            m_drop = 0;
            m_pc   = RESET_PC;
            m_addr = RESET_PC;
            return;
        end
        if (redir) begin
            mq.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pre != 0 && rdy) void'(mq.pop_front());
            if (acked && !m_drop) begin
                mq.push_back({m_addr, m_addr ^ SALT});
                m_pc = m_addr + 32'd4;
            end
        end
        if (!m_out) begin
            start = redir || (pre < DEPTH);
        end else if (acked) begin
            start = mq.size() < DEPTH;
        end else begin
            start = 0;
            if (redir) m_drop = 1;
        end
        if (!m_out || acked) begin
            m_out = start;
            if (start) begin
                m_drop = 0;
                m_addr = m_pc;
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Streaming with immediate ack and ready, then backpressure filling the FIFO.
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h00});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h04});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].rdy, 1'b0, 32'd0);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                      vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Slow memory: request held stable, one entry per ack.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
        check_out("t3_issue", 1'b1, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("t3_hold", 1'b1, 32'h0, 1'b0, 32'h0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0); step();
        check_out("t3_ack", 1'b1, 32'h4, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
        check_out("t3_after", 1'b1, 32'h4, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0); step();
        check_out("t3_one_entry", 1'b1, 32'h4, 1'b0, 32'h0);

        // Redirect while a request is pending without ack.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0); step(); step(); step();
        check_out("t4_pre", 1'b1, 32'h8, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100); step();
        check_out("t4_flush", 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0); step();
        check_out("t4_hold", 1'b1, 32'h8, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); step();
        check_out("t4_drop", 1'b1, 32'h100, 1'b0, 32'h0);
        step();
        check_out("t4_first", 1'b1, 32'h104, 1'b1, 32'h100);
        step();
        check_out("t4_next", 1'b1, 32'h108, 1'b1, 32'h104);

        // Redirect coinciding with ack and pop, unaligned target, then PC wrap.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0); step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); step(); step();
        check_out("t5_pre", 1'b1, 32'h4, 1'b1, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h203); step();
        check_out("t5_redir", 1'b1, 32'h200, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'd0); step();
        check_out("t5_empty", 1'b1, 32'h200, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); step();
        check_out("t5_first", 1'b1, 32'h204, 1'b1, 32'h200);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE); step();
        check_out("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0); step();
        check_out("wrap_inc", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
        step();
        check_out("wrap_next", 1'b1, 32'h4, 1'b1, 32'h0);

        // Reset mid-request with three entries buffered; late ack ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0); step(); step(); step(); step();
        check_out("t6_pre", 1'b1, 32'hC, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0); step();
        check_out("t6_pend", 1'b1, 32'hC, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0); step();
        check_out("t6_rst", 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd0); step();
        check_out("t6_late_ack", 1'b1, 32'h0, 1'b0, 32'h0);
        step();
        check_out("t6_restart", 1'b1, 32'h4, 1'b1, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst;
            bit          r_ack;
            bit          r_rdy;
            bit          r_redir;
            logic [31:0] r_tgt;
            r_rst   = (i == 0) || ($urandom_range(0, 299) == 0);
            r_ack   = $urandom_range(0, 2) != 0;
            r_rdy   = $urandom_range(0, 3) != 0;
            r_redir = $urandom_range(0, 19) == 0;
            r_tgt   = $urandom;
            if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            drive(r_rst, r_ack, r_rdy, r_redir, r_tgt);
            model_step(r_rst, r_ack, r_rdy, r_redir, r_tgt);
            step();
            check("rnd.req", {31'd0, oImemReq}, {31'd0, m_out});
            check("rnd.addr", oImemAddr, m_addr);
            check("rnd.valid", {31'd0, oValid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                check("rnd.pc", oPC, mq[0][63:32]);
                check("rnd.instr", oInstruction, mq[0][31:0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
